// File: rtl/generic_bus_sram_responder.sv
// Responder end of the generic bus: word SRAM with wait states,
// byte-enabled writes, range checking and a preload port.
module generic_bus_sram_responder #(
    parameter int unsigned ADDR_BITS = 10,
    parameter int unsigned LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [31:0]          addr,
    input  logic                 ren,
    input  logic                 wen,
    input  logic [3:0]           byte_en,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata,
    output logic                 busy,
    output logic                 error,
    input  logic                 init_we,
    input  logic [ADDR_BITS-1:0] init_addr,
    input  logic [31:0]          init_data
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;
    localparam logic [3:0]  CNT_RELOAD = 4'(LATENCY - 1);

    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
            $error("LATENCY must be in 1..15");
        end
        if (BASE_ADDR[ADDR_BITS+1:0] != '0) begin : g_bad_base
            $error("BASE_ADDR must be aligned to the memory size");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [31:0]    addr_q, addr_d;
    logic           wr_q, wr_d;
    logic [3:0]     be_q, be_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           error_q, error_d;

    logic [31:0]    mem [DEPTH];

    logic           req;
    logic           changed;
    logic [31:0]    off_d, off_q;
    logic           hit_d, hit_q;
    logic [ADDR_BITS-1:0] idx_d, idx_q;

    assign req     = ren | wen;
    assign changed = (addr != addr_q) || (wen != wr_q) ||
                     (byte_en != be_q) || (wdata != wdata_q);

    // Decode both the request about to be latched and the latched one.
    assign off_d = addr_d - BASE_ADDR;
    assign off_q = addr_q - BASE_ADDR;
    assign hit_d = (addr_d >= BASE_ADDR) && ((off_d >> (ADDR_BITS + 2)) == '0);
    assign hit_q = (addr_q >= BASE_ADDR) && ((off_q >> (ADDR_BITS + 2)) == '0);
    assign idx_d = off_d[ADDR_BITS+1:2];
    assign idx_q = off_q[ADDR_BITS+1:2];

    assign rdata = rdata_q;
    assign error = error_q;

    // Next-state, request latching and combinational busy.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        busy    = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy = req;
                if (req) begin
                    addr_d  = addr;
                    wr_d    = wen;
                    be_d    = byte_en;
                    wdata_d = wdata;
                    cnt_d   = CNT_RELOAD;
                    state_d = (LATENCY == 1) ? DONE : WAIT;
                end
            end
            WAIT: begin
                busy = req;
                if (!req) begin
                    state_d = IDLE;
                end else if (changed) begin
                    addr_d  = addr;
                    wr_d    = wen;
                    be_d    = byte_en;
                    wdata_d = wdata;
                    cnt_d   = CNT_RELOAD;
                    state_d = (LATENCY == 1) ? DONE : WAIT;
                end else if (cnt_q <= 4'd1) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Read data and error are captured on the edge entering DONE.
    always_comb begin
        rdata_d = rdata_q;
        error_d = 1'b0;
        if (state_d == DONE) begin
            error_d = !hit_d;
            if (!wr_d) begin
                rdata_d = hit_d ? mem[idx_d] : 32'h0;
            end
        end
    end

    // Control and request registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'h0;
            wr_q    <= 1'b0;
            be_q    <= 4'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
        end
    end

    // Array: preload first, then bus write lanes override on collision.
    always_ff @(posedge CLK) begin
        if (init_we) begin
            mem[init_addr] <= init_data;
        end
        if (state_q == DONE && wr_q && hit_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: doc/generic_bus_sram_responder.md
Name: generic_bus_sram_responder

Overview:
- Responder (slave) end of generic_bus_if: the memory side that answers the CPU-side initiators, i.e. the instruction fetch port and the data port.
- Word-organised SRAM model with a programmable wait-state count, byte-enabled writes, range checking and a preload port.
- Used as the instruction/data memory behind the stage3 pipeline in simulation and FPGA builds.
- Follows the generic bus rule: `busy` low for exactly one cycle marks completion.

Parameters:
- ADDR_BITS, 10: log2 of memory depth in 32-bit words.
- LATENCY, 2: cycles `busy` is held high per transaction. Legal range 1..15; elaboration fails outside it.
- BASE_ADDR, 32'h8000_0000: byte address of word 0. Must be aligned to 4*2^ADDR_BITS.

Ports:
- CLK  input  1  clock.
- nRST  input  1  asynchronous active-low reset.
- addr  input  32  byte address from initiator.
- ren  input  1  read request.
- wen  input  1  write request; priority over ren.
- byte_en  input  4  write lane enables; bit i selects wdata[8i+7:8i].
- wdata  input  32  write data.
- rdata  output  32  read data; valid in the completion cycle, held afterwards.
- busy  output  1  1 = request pending, not complete.
- error  output  1  1 in completion cycle if the address was out of range.
- init_we  input  1  preload write strobe.
- init_addr  input  ADDR_BITS  preload word index.
- init_data  input  32  preload word.

Behaviour:
- Reset: async on nRST low. State IDLE, counter 0, rdata 32'h0, error 0, latched request cleared. Array contents are not reset.
- busy is combinational:
  - 1 in IDLE or WAIT when (ren|wen)=1.
  - 0 in DONE.
  - 0 when there is no request.
  - During reset, busy follows ren|wen (state is IDLE).
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - (ren|wen)=1 → latch addr, op (write if wen, else read), byte_en, wdata.
  - LATENCY=1 → next DONE; otherwise next WAIT with cnt=LATENCY-1.
  - No request → stay.
- WAIT:
  - cnt decrements each cycle; when cnt reaches 1 → next DONE.
  - Request dropped (ren|wen=0), i.e. an abort/flush → IDLE. Nothing written; rdata and error unchanged.
  - addr, op, byte_en or wdata differ from the latched values → restart: re-latch, cnt=LATENCY-1, full latency again. LATENCY=1 goes straight to DONE.
- DONE (one cycle): busy=0, then next IDLE.
  - Read: rdata = mem[index], registered on the edge entering DONE.
  - Write: array updated on the edge leaving DONE, only lanes with byte_en=1.
  - error=1 if out of range; otherwise 0. error is 0 in all other states.
- Timing: a request first presented in cycle t, and held, completes with busy=0 in cycle t+LATENCY.
  - A held ren causes back-to-back transactions, one completion every LATENCY+1 cycles.
  - A new request is only sampled in IDLE, so the cycle after DONE always shows busy=1 if the request is held.
- Address decode:
  - offset = addr - BASE_ADDR; index = offset[ADDR_BITS+1:2].
  - addr[1:0] is ignored: accesses are word-aligned and no misalignment error is raised (initiator flags it).
  - In range iff BASE_ADDR <= addr < BASE_ADDR + 4*2^ADDR_BITS, 32-bit unsigned compare, no wrap.
  - Out of range: read returns 32'h0, write dropped, error=1 in DONE.
- Preload:
  - init_we writes mem[init_addr]=init_data on that edge in any state.
  - Same-edge collision with a DONE write to the same index: bus write wins per enabled byte, preload fills disabled bytes.
  - Read in DONE of a word preloaded on the entry edge returns the old value (read-before-write).
- ren and wen both high: treated as write.

Test Plan:
- Reset, preload mem[0]=32'h0000_0013, LATENCY=2, ren=1 addr=32'h8000_0000 held → busy 1,1,0 then rdata=32'h0000_0013, error=0, and busy=1 the next cycle.
- Write addr=32'h8000_0004 wdata=32'hAABB_CCDD byte_en=4'b0101 over preload 32'h1122_3344, then read → 32'h11BB_33DD.
- ren with addr=32'h8000_1000 (ADDR_BITS=10, out of range) → busy low after 2 cycles, rdata=0, error=1 for one cycle only; addr=32'h7FFF_FFFC likewise error=1.
- addr changed 32'h8000_0000→32'h8000_0008 in WAIT → busy stays high 2 more cycles, then returns mem[2]. Dropping ren mid-WAIT → IDLE, busy=0, a pending write is not performed.
- LATENCY=1, ren held on consecutive addresses → busy pattern 1,0,1,0; rdata updates on each 0 cycle.
- Assert nRST low during WAIT of a write → busy=ren|wen, rdata=0, target word unchanged after reset release.
